// File: rtl/ex_div_unit_pkg.sv
// ex_div_unit_pkg
//   Shared definitions for the EX-stage divider.
//   - Default operand width and iteration counter width.
//   - Divider FSM state codes (free / divide-by-zero / running / result).
//   - Ready / not-ready encodings of div_ready.
package ex_div_unit_pkg;

  localparam int DIV_DW    = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/ex_div_unit_step.sv
// ex_div_unit_step
//   One combinational restoring-division iteration (the div_step
//   operation). The working register holds {remainder, quotient}:
//   the pair is shifted left by one, the divisor magnitude is
//   trial-subtracted from the shifted remainder and, when the result
//   is non-negative, the remainder is replaced and the new quotient
//   bit is set.
// Ports
//   rem_quo      in   2*DW  current {remainder, quotient}
//   divisor      in   DW    divisor magnitude
//   rem_quo_nxt  out  2*DW  {remainder, quotient} after this step
module ex_div_unit_step #(
  parameter int DW = 32
) (
  input  logic [2*DW-1:0] rem_quo,
  input  logic [DW-1:0]   divisor,
  output logic [2*DW-1:0] rem_quo_nxt
);

  // The remainder entering a step is below the divisor, so after the
  // shift it needs DW+1 bits. The trial difference is then either in
  // [0, divisor) with bit DW clear, or negative with bit DW set, which
  // makes bit DW a clean "did not fit" flag.
  logic [DW:0] partial;
  logic [DW:0] trial;
  logic        fits;

  assign partial = rem_quo[2*DW-1:DW-1];
  assign trial   = partial - {1'b0, divisor};
  assign fits    = ~trial[DW];

  always_comb begin
    rem_quo_nxt = {rem_quo[2*DW-2:0], 1'b0};
    if (fits) begin
      rem_quo_nxt = {trial[DW-1:0], rem_quo[DW-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_div_unit.sv
// ex_div_unit
//   Multi-cycle integer divider in the EX stage (MIPS DIV / DIVU).
//   Raises stallreq_from_ex while a divide is outstanding so the stall
//   controller freezes PC/IF/ID/EX; the result goes to the HI/LO path.
//   Optional build macro: DIV_EARLY_OUT_EN -- when |dividend| < |divisor|
//   the result (quotient 0, remainder = dividend) is produced one cycle
//   after issue instead of running all DW iterations.
// Ports
//   clk              in   1     pipeline clock
//   rst              in   1     synchronous, active-high reset
//   div_start        in   1     held by EX from issue until it sees div_ready
//   div_signed       in   1     1 = DIV (two's complement), 0 = DIVU
//   div_opdata1      in   DW    dividend
//   div_opdata2      in   DW    divisor
//   div_annul        in   1     cancel the current operation
//   div_result       out  2*DW  {remainder (HI), quotient (LO)}
//   div_ready        out  1     div_result valid
//   stallreq_from_ex out  1     stall request
//   dbg_state        out  2     current FSM state code
// Handshake: EX raises div_start with stable operands and keeps it high
//   until it samples div_ready=1; the unit then holds the result while
//   div_start stays high and returns to idle the cycle after it drops.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int DW    = DIV_DW,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_start,
  input  logic            div_signed,
  input  logic [DW-1:0]   div_opdata1,
  input  logic [DW-1:0]   div_opdata2,
  input  logic            div_annul,
  output logic [2*DW-1:0] div_result,
  output logic            div_ready,
  output logic            stallreq_from_ex,
  output logic [1:0]      dbg_state
);

  div_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DW-1:0]     dvs_mag;
  logic [2*DW-1:0]   rem_quo;
  logic [2*DW-1:0]   step_out;
  logic              neg_quo;
  logic              neg_rem;

  // Operand magnitudes; DIVU treats both operands as non-negative.
  logic              op1_neg, op2_neg;
  logic [DW-1:0]     op1_mag, op2_mag;
  logic              early_out;

  assign op1_neg = div_signed & div_opdata1[DW-1];
  assign op2_neg = div_signed & div_opdata2[DW-1];
  assign op1_mag = op1_neg ? (~div_opdata1 + 1'b1) : div_opdata1;
  assign op2_mag = op2_neg ? (~div_opdata2 + 1'b1) : div_opdata2;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (op1_mag < op2_mag);
`else
  assign early_out = 1'b0;
`endif

  ex_div_unit_step #(.DW(DW)) u_step (
    .rem_quo     (rem_quo),
    .divisor     (dvs_mag),
    .rem_quo_nxt (step_out)
  );

  // Sign fix-up applied to the final step: quotient negative when the
  // operand signs differ, remainder follows the dividend sign. The
  // 0x80000000 / -1 case wraps naturally to 0x80000000.
  logic [DW-1:0] quo_fix, rem_fix;
  assign quo_fix = neg_quo ? (~step_out[DW-1:0] + 1'b1) : step_out[DW-1:0];
  assign rem_fix = neg_rem ? (~step_out[2*DW-1:DW] + 1'b1) : step_out[2*DW-1:DW];

  logic            load_op;
  logic            do_step;
  logic            res_load;
  logic [2*DW-1:0] res_val;

  always_comb begin
    state_nxt = state;
    load_op   = 1'b0;
    do_step   = 1'b0;
    res_load  = 1'b0;
    res_val   = '0;
    case (state)
      DIV_FREE: begin
        if (div_start && !div_annul) begin
          if (div_opdata2 == '0) begin
            state_nxt = DIV_BY_ZERO;
          end else if (early_out) begin
            state_nxt = DIV_END;
            res_load  = 1'b1;
            res_val   = {div_opdata1, {DW{1'b0}}};
          end else begin
            state_nxt = DIV_ON;
            load_op   = 1'b1;
          end
        end
      end
      DIV_BY_ZERO: begin
        if (div_annul) begin
          state_nxt = DIV_FREE;
        end else begin
          state_nxt = DIV_END;
          res_load  = 1'b1;
        end
      end
      DIV_ON: begin
        if (div_annul) begin
          state_nxt = DIV_FREE;
        end else begin
          do_step = 1'b1;
          if (cnt == CNT_W'(DW - 1)) begin
            state_nxt = DIV_END;
            res_load  = 1'b1;
            res_val   = {rem_fix, quo_fix};
          end
        end
      end
      DIV_END: begin
        if (div_annul || !div_start) begin
          state_nxt = DIV_FREE;
        end
      end
      default: state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DIV_FREE;
      cnt        <= '0;
      dvs_mag    <= '0;
      rem_quo    <= '0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
      div_result <= '0;
    end else begin
      state <= state_nxt;
      if (load_op) begin
        cnt     <= '0;
        dvs_mag <= op2_mag;
        rem_quo <= {{DW{1'b0}}, op1_mag};
        neg_quo <= op1_neg ^ op2_neg;
        neg_rem <= op1_neg;
      end
      if (do_step) begin
        rem_quo <= step_out;
        cnt     <= cnt + 1'b1;
      end
      if (res_load) begin
        div_result <= res_val;
      end
    end
  end

  assign div_ready        = (state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign stallreq_from_ex = div_start & ~div_ready;
  assign dbg_state        = state;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit
//   Directed bench for ex_div_unit: reset values, DIVU/DIV results,
//   latency and stall window, divide-by-zero, overflow wrap, annul,
//   mid-operation reset and the small-dividend case.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] div_opdata1 = '0;
  logic [31:0] div_opdata2 = '0;
  logic        div_annul = 1'b0;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stallreq_from_ex;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  ex_div_unit dut (
    .clk              (clk),
    .rst              (rst),
    .div_start        (div_start),
    .div_signed       (div_signed),
    .div_opdata1      (div_opdata1),
    .div_opdata2      (div_opdata2),
    .div_annul        (div_annul),
    .div_result       (div_result),
    .div_ready        (div_ready),
    .stallreq_from_ex (stallreq_from_ex),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Issues one divide at a negedge (cycle 0), holds div_start until
  // div_ready is seen, holds one more cycle, then drops div_start.
  // lat counts rising edges from issue to the first ready cycle.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res, output int stall_bad,
                         output logic held, output logic released);
    @(negedge clk);
    div_signed  = sgn;
    div_opdata1 = a;
    div_opdata2 = b;
    div_start   = 1'b1;
    #1;
    stall_bad = 0;
    lat = 0;
    res = '0;
    held = 1'b0;
    released = 1'b1;
    if (stallreq_from_ex !== 1'b1) stall_bad++;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (div_ready === 1'b1) break;
      if (stallreq_from_ex !== 1'b1) stall_bad++;
    end
    if (div_ready === 1'b1) begin
      if (stallreq_from_ex !== 1'b0) stall_bad++;
      res = div_result;
      @(posedge clk);
      @(negedge clk);
      held = div_ready;
    end
    div_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    released = div_ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (div_result !== 64'd0) begin
      errors++; $display("FAIL reset_result got %h exp %h", div_result, 64'd0);
    end
    checks++;
    if (div_ready !== 1'b0 || stallreq_from_ex !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_flags got rdy=%b stall=%b st=%0d exp 0 0 0",
                         div_ready, stallreq_from_ex, dbg_state);
    end
  endtask

  task automatic test_divu();
    logic [31:0] va[3] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vb[3] = '{32'd7,   32'd1,         32'hFFFF_FFFE};
    logic [63:0] ve[3] = '{{32'd2, 32'd14}, {32'd0, 32'hFFFF_FFFF}, {32'd1, 32'd1}};
    int lat, sb;
    logic [63:0] res;
    logic held, rel;
    for (int i = 0; i < 3; i++) begin
      run_div(1'b0, va[i], vb[i], lat, res, sb, held, rel);
      checks++;
      if (res !== ve[i]) begin
        errors++; $display("FAIL divu_result[%0d] got %h exp %h", i, res, ve[i]);
      end
      checks++;
      if (lat !== 33) begin
        errors++; $display("FAIL divu_latency[%0d] got %0d exp 33", i, lat);
      end
      checks++;
      if (sb !== 0) begin
        errors++; $display("FAIL divu_stall_window[%0d] got %0d bad cycles exp 0", i, sb);
      end
      checks++;
      if (held !== 1'b1 || rel !== 1'b0) begin
        errors++; $display("FAIL divu_end_hold[%0d] got held=%b released=%b exp 1 0", i, held, rel);
      end
    end
  endtask

  task automatic test_signed();
    logic [31:0] va[3] = '{32'hFFFF_FFF9, 32'd7,         32'h8000_0000};
    logic [31:0] vb[3] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [63:0] ve[3] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD},
                           {32'h0000_0001, 32'hFFFF_FFFD},
                           {32'h0000_0000, 32'h8000_0000}};
    int lat, sb;
    logic [63:0] res;
    logic held, rel;
    for (int i = 0; i < 3; i++) begin
      run_div(1'b1, va[i], vb[i], lat, res, sb, held, rel);
      checks++;
      if (res !== ve[i] || lat !== 33) begin
        errors++; $display("FAIL div_signed[%0d] got %h lat %0d exp %h lat 33", i, res, lat, ve[i]);
      end
    end
  endtask

  task automatic test_by_zero();
    int lat, sb;
    logic [63:0] res;
    logic held, rel;
    run_div(1'b0, 32'd5, 32'd0, lat, res, sb, held, rel);
    checks++;
    if (res !== 64'd0 || lat !== 2) begin
      errors++; $display("FAIL div_by_zero got %h lat %0d exp 0 lat 2", res, lat);
    end
    checks++;
    if (sb !== 0) begin
      errors++; $display("FAIL div_by_zero_stall got %0d bad cycles exp 0", sb);
    end
  endtask

  task automatic test_annul();
    int lat, sb;
    logic [63:0] res;
    logic held, rel;
    // Last completed result was 0 (divide-by-zero).
    @(negedge clk);
    div_signed  = 1'b0;
    div_opdata1 = 32'd100;
    div_opdata2 = 32'd7;
    div_start   = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    div_annul = 1'b1;
    div_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    div_annul = 1'b0;
    checks++;
    if (dbg_state !== 2'd0 || div_ready !== 1'b0) begin
      errors++; $display("FAIL annul_idle got st=%0d rdy=%b exp 0 0", dbg_state, div_ready);
    end
    checks++;
    if (div_result !== 64'd0) begin
      errors++; $display("FAIL annul_result_kept got %h exp %h", div_result, 64'd0);
    end
    run_div(1'b0, 32'd9, 32'd3, lat, res, sb, held, rel);
    checks++;
    if (res !== {32'd0, 32'd3} || lat !== 33) begin
      errors++; $display("FAIL annul_next_div got %h lat %0d exp %h lat 33", res, lat, {32'd0, 32'd3});
    end
  endtask

  task automatic test_rst_mid();
    int lat, sb;
    logic [63:0] res;
    logic held, rel;
    @(negedge clk);
    div_signed  = 1'b0;
    div_opdata1 = 32'd100;
    div_opdata2 = 32'd7;
    div_start   = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    div_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (div_result !== 64'd0 || div_ready !== 1'b0 || stallreq_from_ex !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL rst_mid got res=%h rdy=%b stall=%b st=%0d exp all 0",
                         div_result, div_ready, stallreq_from_ex, dbg_state);
    end
    run_div(1'b0, 32'd100, 32'd7, lat, res, sb, held, rel);
    checks++;
    if (res !== {32'd2, 32'd14} || lat !== 33) begin
      errors++; $display("FAIL rst_mid_next_div got %h lat %0d exp %h lat 33", res, lat, {32'd2, 32'd14});
    end
  endtask

  task automatic test_early_out();
    int lat, sb, exp_lat;
    logic [63:0] res;
    logic held, rel;
`ifdef DIV_EARLY_OUT_EN
    exp_lat = 1;
`else
    exp_lat = 33;
`endif
    run_div(1'b0, 32'd3, 32'd10, lat, res, sb, held, rel);
    checks++;
    if (res !== {32'd3, 32'd0} || lat !== exp_lat) begin
      errors++; $display("FAIL small_dividend got %h lat %0d exp %h lat %0d", res, lat, {32'd3, 32'd0}, exp_lat);
    end
    run_div(1'b1, 32'hFFFF_FFFD, 32'd10, lat, res, sb, held, rel);
    checks++;
    if (res !== {32'hFFFF_FFFD, 32'd0} || lat !== exp_lat) begin
      errors++; $display("FAIL small_dividend_signed got %h lat %0d exp %h lat %0d",
                         res, lat, {32'hFFFF_FFFD, 32'd0}, exp_lat);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_by_zero();
    test_annul();
    test_rst_mid();
    test_early_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
